sar_search_4bit: RTL and testbench
==================================

SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 Parameter: W, default 4, search width in bits; legal range 2..8.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: start  in  1  begin search; sampled only in IDLE.
REQ-005 Port: probe  out  W  value driven to external comparator B input; comparator A holds unknown target.
REQ-006 Port: cmp_en  out  1  comparator enable; high only while a probe is presented.
REQ-007 Port: cmp_eq, cmp_gt, cmp_lt  in  1 each  comparator flags (A==B, A>B, A<B).
REQ-008 Port: busy  out  1  high in any state other than IDLE.
REQ-009 Port: done  out  1  one-cycle completion pulse.
REQ-010 Port: result  out  W  located target value; valid from done until next accepted start.
REQ-011 Port: found  out  1  result valid; held with result.
REQ-012 Port: err  out  1  flag protocol violation or exhausted range; held with result.
REQ-013 Port: steps  out  4  comparisons performed in last search; held with result.

Function
REQ-014 States: IDLE, SEARCH, DONE (plus SETTLE when configured); binary search over lo..hi using W+1-bit bounds.
REQ-015 IDLE + start=1 -> SEARCH; lo=0, hi=2^W-1, steps=0, found=0, err=0, result=0.
REQ-016 probe = (lo+hi)>>1, truncated to W bits; cmp_en=1 in SEARCH/SETTLE, 0 elsewhere; probe=0 when cmp_en=0.
REQ-017 SEARCH samples flags each edge, steps+=1: eq -> result=probe, found=1, go DONE; gt -> lo=probe+1; lt -> hi=probe-1.
REQ-018 gt with probe=2^W-1, or lt with probe=0 -> err=1, found=0, go DONE (range exhausted, no wrap-around).
REQ-019 Zero flags or more than one flag high at sample -> err=1, found=0, go DONE; bounds unchanged.
REQ-020 Latency: N comparisons -> done high in the cycle after the Nth sampling edge, i.e. N cycles after the start-sampling edge; N <= W+1.
REQ-021 DONE lasts exactly one cycle (done=1), then IDLE; start during SEARCH/DONE ignored, no queueing.
REQ-022 start held high in IDLE at DONE->IDLE return launches a new search on the next edge.

Reset
REQ-023 rst_n low: state=IDLE, lo=0, hi=0, probe=0, cmp_en=0, busy=0, done=0, result=0, found=0, err=0, steps=0, immediately and asynchronously.
REQ-024 Reset mid-search aborts with no done pulse; first start after release begins a fresh search.

Configuration
REQ-025 Macro SAR_SEARCH_SETTLE_EN defined: each probe spends one SETTLE cycle (cmp_en=1, flags ignored) before its SEARCH sampling cycle; latency 2N.
REQ-026 Macro undefined: no SETTLE state; flags sampled in the same cycle the probe is first driven; latency N.

Structure
REQ-027 Package sar_search_pkg holds state enum, default W, steps width constant and flag-check helper function.
REQ-028 One sub-module, sar_search_next: combinational next lo/hi/midpoint and exhaustion/error decode; FSM and registers stay in top.

Verification
REQ-029 W=4, model target A=7, start pulse -> probe 7, eq; done 1 cycle after start edge; result=7, found=1, steps=1.
REQ-030 A=15 -> probes 7,11,13,14,15; done 5 cycles after start; result=15, steps=5, err=0.
REQ-031 A=0 -> probes 7,3,1,0; result=0, steps=4; with SAR_SEARCH_SETTLE_EN done 8 cycles after start.
REQ-032 Model forces no flag on first sample -> err=1, found=0, steps=1, done pulse; forced cmp_gt at probe 15 -> err=1.
REQ-033 rst_n low during third probe of A=13 search -> all outputs 0 at once, no done; re-start finds 13 in 3 steps.
REQ-034 start held high across search -> second start ignored while busy; new search begins edge after return to IDLE.

Source files
------------

// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search block.
package sar_search_pkg;

  localparam int unsigned DefaultW = 4;
  localparam int unsigned StepsW   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSearch,
    StDone
  } state_e;

  // Exactly one comparator flag must be high for a sample to be trusted.
  function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
    return (eq ^ gt ^ lt) && !(eq && gt && lt);
  endfunction

endpackage

// File: rtl/sar_search_next.sv
// Combinational step of the binary search: midpoint, next bounds, hit and error decode.
module sar_search_next
  import sar_search_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic [W:0]   i_lo,
  input  logic [W:0]   i_hi,
  input  logic         i_eq,
  input  logic         i_gt,
  input  logic         i_lt,
  output logic [W-1:0] o_mid,
  output logic [W:0]   o_lo,
  output logic [W:0]   o_hi,
  output logic         o_hit,
  output logic         o_err
);

  localparam logic [W:0] One    = (W+1)'(1);
  localparam logic [W:0] MaxMid = {1'b0, {W{1'b1}}};

  logic [W:0] w_mid_ext;
  logic [W:0] w_lo_inc;
  logic [W:0] w_hi_dec;

  // floor((lo+hi)/2) without needing a wider adder
  assign w_mid_ext = (i_lo >> 1) + (i_hi >> 1) + {{W{1'b0}}, i_lo[0] & i_hi[0]};
  assign w_lo_inc  = w_mid_ext + One;
  assign w_hi_dec  = w_mid_ext - One;
  assign o_mid     = w_mid_ext[W-1:0];

  always_comb begin
    o_lo  = i_lo;
    o_hi  = i_hi;
    o_hit = 1'b0;
    o_err = 1'b0;
    if (!flags_onehot(i_eq, i_gt, i_lt)) begin
      o_err = 1'b1;
    end else if (i_eq) begin
      o_hit = 1'b1;
    end else if (i_gt) begin
      if (w_mid_ext == MaxMid || w_lo_inc > i_hi) o_err = 1'b1;
      else                                        o_lo  = w_lo_inc;
    end else begin
      // guard mid==0 first: w_hi_dec wraps there
      if (w_mid_ext == '0 || w_hi_dec < i_lo) o_err = 1'b1;
      else                                    o_hi  = w_hi_dec;
    end
  end

endmodule

// File: rtl/sar_search_4bit.sv
// Binary search of an external comparator's hidden value. Define SAR_SEARCH_SETTLE_EN to
// insert one comparator settle cycle before each sampling cycle.
module sar_search_4bit
  import sar_search_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [W-1:0]      probe,
  output logic              cmp_en,
  input  logic              cmp_eq,
  input  logic              cmp_gt,
  input  logic              cmp_lt,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      result,
  output logic              found,
  output logic              err,
  output logic [StepsW-1:0] steps
);

`ifdef SAR_SEARCH_SETTLE_EN
  localparam state_e StProbe = StSettle;
`else
  localparam state_e StProbe = StSearch;
`endif

  localparam logic [StepsW-1:0] StepOne = StepsW'(1);

  state_e            r_state, w_state_nxt;
  logic [W:0]        r_lo, r_hi, w_lo_nxt, w_hi_nxt;
  logic [W-1:0]      r_result, w_result_nxt;
  logic              r_found, w_found_nxt;
  logic              r_err, w_err_nxt;
  logic [StepsW-1:0] r_steps, w_steps_nxt;

  logic [W-1:0] w_mid;
  logic [W:0]   w_lo_step, w_hi_step;
  logic         w_hit, w_flag_err;

  sar_search_next #(
    .W (W)
  ) u_next (
    .i_lo  (r_lo),
    .i_hi  (r_hi),
    .i_eq  (cmp_eq),
    .i_gt  (cmp_gt),
    .i_lt  (cmp_lt),
    .o_mid (w_mid),
    .o_lo  (w_lo_step),
    .o_hi  (w_hi_step),
    .o_hit (w_hit),
    .o_err (w_flag_err)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_result_nxt = r_result;
    w_found_nxt  = r_found;
    w_err_nxt    = r_err;
    w_steps_nxt  = r_steps;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt  = StProbe;
          w_lo_nxt     = '0;
          w_hi_nxt     = {1'b0, {W{1'b1}}};
          w_result_nxt = '0;
          w_found_nxt  = 1'b0;
          w_err_nxt    = 1'b0;
          w_steps_nxt  = '0;
        end
      end
      StSettle: w_state_nxt = StSearch;
      StSearch: begin
        w_steps_nxt = r_steps + StepOne;
        if (w_flag_err) begin
          w_err_nxt   = 1'b1;
          w_found_nxt = 1'b0;
          w_state_nxt = StDone;
        end else if (w_hit) begin
          w_result_nxt = w_mid;
          w_found_nxt  = 1'b1;
          w_state_nxt  = StDone;
        end else begin
          w_lo_nxt    = w_lo_step;
          w_hi_nxt    = w_hi_step;
          w_state_nxt = StProbe;
        end
      end
      StDone: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_lo     <= '0;
      r_hi     <= '0;
      r_result <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_steps  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_result <= w_result_nxt;
      r_found  <= w_found_nxt;
      r_err    <= w_err_nxt;
      r_steps  <= w_steps_nxt;
    end
  end

  assign cmp_en = (r_state == StSearch) || (r_state == StSettle);
  assign probe  = cmp_en ? w_mid : '0;
  assign busy   = (r_state != StIdle);
  assign done   = (r_state == StDone);
  assign result = r_result;
  assign found  = r_found;
  assign err    = r_err;
  assign steps  = r_steps;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench for sar_search_4bit with a behavioural comparator holding the target.
module tb_sar_search_4bit;

`ifdef SAR_SEARCH_SETTLE_EN
  localparam int LatMul = 2;
`else
  localparam int LatMul = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] probe;
  logic       cmp_en, cmp_eq, cmp_gt, cmp_lt;
  logic       busy, done, found, err;
  logic [3:0] result;
  logic [3:0] steps;

  logic [3:0] tgt = 4'd0;
  int         mode = 0;  // 0 normal, 1 no flags, 2 gt forced at 15, 3 all flags, 4 lt forced at 0
  int         checks = 0;
  int         failures = 0;
  int         n;

  always #5 clk = ~clk;

  sar_search_4bit #(
    .W (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .probe  (probe),
    .cmp_en (cmp_en),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err),
    .steps  (steps)
  );

  always_comb begin
    cmp_eq = (probe == tgt);
    cmp_gt = (tgt > probe);
    cmp_lt = (tgt < probe);
    if (mode == 1) begin
      cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0;
    end else if (mode == 2 && probe == 4'hF) begin
      cmp_eq = 1'b0; cmp_gt = 1'b1; cmp_lt = 1'b0;
    end else if (mode == 3) begin
      cmp_eq = 1'b1; cmp_gt = 1'b1; cmp_lt = 1'b1;
    end else if (mode == 4 && probe == 4'h0) begin
      cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one search and check probe trail, latency and held results.
  task automatic do_search(input string tag, input logic [3:0] t, input int m,
                           input logic [31:0] exp_probes, input int exp_n,
                           input logic [3:0] exp_res, input logic exp_found,
                           input logic exp_err);
    logic [31:0] rec;
    logic [3:0]  last;
    int          nrec;
    int          lat;
    rec  = '0;
    last = '0;
    nrec = 0;
    lat  = 0;
    tgt  = t;
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && lat < 40) begin
      if (cmp_en && (nrec == 0 || probe != last)) begin
        rec  = {rec[27:0], probe};
        last = probe;
        nrec++;
      end
      tick();
      lat++;
    end
    chk({tag, "_probes"}, rec, exp_probes);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_n * LatMul));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_found"}, 32'(found), 32'(exp_found));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_steps"}, 32'(steps), 32'(exp_n));
    tick();
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_held"}, 32'(result), 32'(exp_res));
    mode = 0;
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmp_en", 32'(cmp_en), 32'd0);
    chk("rst_probe", 32'(probe), 32'd0);
    chk("rst_steps", 32'(steps), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    do_search("a7", 4'd7, 0, 32'h7, 1, 4'd7, 1'b1, 1'b0);
    do_search("a15", 4'd15, 0, 32'h7BDEF, 5, 4'd15, 1'b1, 1'b0);
    do_search("a0", 4'd0, 0, 32'h7310, 4, 4'd0, 1'b1, 1'b0);
    do_search("a10", 4'd10, 0, 32'h7B9A, 4, 4'd10, 1'b1, 1'b0);
    do_search("a1", 4'd1, 0, 32'h731, 3, 4'd1, 1'b1, 1'b0);
    do_search("noflag", 4'd5, 1, 32'h7, 1, 4'd0, 1'b0, 1'b1);
    do_search("multiflag", 4'd5, 3, 32'h7, 1, 4'd0, 1'b0, 1'b1);
    do_search("gt_at_max", 4'd15, 2, 32'h7BDEF, 5, 4'd0, 1'b0, 1'b1);
    do_search("lt_at_zero", 4'd0, 4, 32'h7310, 4, 4'd0, 1'b0, 1'b1);

    // Abort a search for 13 while its third probe is on the bus.
    tgt = 4'd13;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(cmp_en && probe == 4'd13) && n < 40) begin
      tick();
      n++;
    end
    chk("abort_reach", 32'(probe), 32'd13);
    chk("abort_steps_pre", 32'(steps), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_probe", 32'(probe), 32'd0);
    chk("abort_cmp_en", 32'(cmp_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_found", 32'(found), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_steps", 32'(steps), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    do_search("a13_after_rst", 4'd13, 0, 32'h7BD, 3, 4'd13, 1'b1, 1'b0);

    // Start held high: ignored while busy, relaunches right after returning to idle.
    tgt = 4'd7;
    start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("hold_latency", 32'(n), 32'(LatMul));
    chk("hold_done", 32'(done), 32'd1);
    tick();
    chk("hold_idle", 32'(busy), 32'd0);
    chk("hold_result", 32'(result), 32'd7);
    tick();
    chk("hold_relaunch_busy", 32'(busy), 32'd1);
    chk("hold_relaunch_cmp_en", 32'(cmp_en), 32'd1);
    chk("hold_relaunch_probe", 32'(probe), 32'd7);
    chk("hold_relaunch_found", 32'(found), 32'd0);
    chk("hold_relaunch_steps", 32'(steps), 32'd0);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("hold_second_done", 32'(done), 32'd1);
    chk("hold_second_result", 32'(result), 32'd7);
    chk("hold_second_steps", 32'(steps), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
